// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2), decode (T3), execute (T4-T6) with sticky Stop and HALT.
// Define MULDIV_EN to enable the MUL/DIV path (state T6, LOin/HIin/Zhighout); otherwise those opcodes run as NOP.
module control_sequencer (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        LOin,
    output logic        HIin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHL,
    output logic        MUL,
    output logic        DIV,
    output logic        Run,
    output logic [3:0]  state_dbg
);
    typedef enum logic [3:0] {
        RESET_S = 4'd0,
        T0      = 4'd1,
        T1      = 4'd2,
        T2      = 4'd3,
        T3      = 4'd4,
        T4      = 4'd5,
        T5      = 4'd6,
`ifdef MULDIV_EN
        T6      = 4'd7,
`endif
        HALT    = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_MUL, OP_DIV
    } op_e;

    typedef enum logic [1:0] {DEC_NOP, DEC_ALU, DEC_HALT} dec_e;

    state_e state_q, state_d;
    op_e    op_q, op_d;
    logic   stop_q, stop_d;
    op_e    dec_op;
    dec_e   dec_kind;
    state_e fetch_next;
    logic   unused_ir;

    assign unused_ir  = ^IR[26:0];
    assign state_dbg  = state_q;
    // Stop seen on the same edge as a fetch boundary already counts.
    assign stop_d     = stop_q | Stop;
    assign fetch_next = stop_d ? HALT : T0;

    always_comb begin : decode
        dec_op   = OP_ADD;
        dec_kind = DEC_ALU;
        case (IR[31:27])
            5'b00011: dec_op = OP_ADD;
            5'b00100: dec_op = OP_SUB;
            5'b00101: dec_op = OP_AND;
            5'b00110: dec_op = OP_OR;
            5'b00111: dec_op = OP_SHR;
            5'b01000: dec_op = OP_SHL;
`ifdef MULDIV_EN
            5'b01111: dec_op = OP_MUL;
            5'b10000: dec_op = OP_DIV;
`endif
            5'b11011: dec_kind = DEC_HALT;
            default:  dec_kind = DEC_NOP;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= RESET_S;
            op_q    <= OP_ADD;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin : fsm
        state_d  = state_q;
        op_d     = op_q;
        PCout    = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
        MARin    = 1'b0; Zin     = 1'b0; PCin     = 1'b0; MDRin  = 1'b0;
        IRin     = 1'b0; Yin     = 1'b0; LOin     = 1'b0; HIin   = 1'b0;
        IncPC    = 1'b0; Read    = 1'b0;
        Gra      = 1'b0; Grb     = 1'b0; Grc      = 1'b0; Rin    = 1'b0; Rout = 1'b0;
        ADD      = 1'b0; SUB     = 1'b0; AND      = 1'b0; OR     = 1'b0;
        SHR      = 1'b0; SHL     = 1'b0; MUL      = 1'b0; DIV    = 1'b0;
        Run      = (state_q != RESET_S) && (state_q != HALT);
        case (state_q)
            RESET_S: state_d = fetch_next;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_d = T1;
            end
            T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                state_d = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_d = T3;
            end
            T3: begin
                // Opcode is captured here so later IR changes cannot redirect T4-T6.
                op_d = dec_op;
                case (dec_kind)
                    DEC_ALU: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        state_d = T4;
                    end
                    DEC_HALT: state_d = HALT;
                    default:  state_d = fetch_next;
                endcase
            end
            T4: begin
                Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                case (op_q)
                    OP_ADD: ADD = 1'b1;
                    OP_SUB: SUB = 1'b1;
                    OP_AND: AND = 1'b1;
                    OP_OR:  OR  = 1'b1;
                    OP_SHR: SHR = 1'b1;
                    OP_SHL: SHL = 1'b1;
`ifdef MULDIV_EN
                    OP_MUL: MUL = 1'b1;
                    OP_DIV: DIV = 1'b1;
`endif
                    default: ;
                endcase
                state_d = T5;
            end
            T5: begin
                Zlowout = 1'b1;
`ifdef MULDIV_EN
                if (op_q == OP_MUL || op_q == OP_DIV) begin
                    LOin    = 1'b1;
                    state_d = T6;
                end else
`endif
                begin
                    Gra = 1'b1; Rin = 1'b1;
                    state_d = fetch_next;
                end
            end
`ifdef MULDIV_EN
            T6: begin
                Zhighout = 1'b1; HIin = 1'b1;
                state_d = fetch_next;
            end
`endif
            HALT:    state_d = HALT;
            default: state_d = RESET_S;
        endcase
    end
endmodule
